// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, FSM + shift register + parity.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK state.
module uart_tx_param #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              baud_tick,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_en,
  input  logic              parity_odd,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int CW = $clog2(DATA_W);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA,
    S_PARITY, S_STOP, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA,
    S_PARITY, S_STOP
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shreg_nxt;
  logic [CW-1:0]       r_bit_cnt;
  logic                r_stop_cnt;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_tx;
  logic                r_busy;
  logic                w_tx_nxt;
  logic                w_accept;
  logic                w_last_bit;
  logic                w_last_stop;
  logic                w_brk;

`ifdef UART_TX_BREAK_EN
  assign w_brk = tx_break;
`else
  assign w_brk = 1'b0;
`endif

  // Break wins over a simultaneous start request.
  assign w_accept    = tx_start & tx_ready & ~w_brk;
  assign w_last_bit  = (r_bit_cnt == CW'(DATA_W - 1));
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_brk)
          w_state_nxt = S_IDLE_BRK();
        else if (w_accept)
          w_state_nxt = S_SYNC;
      end
      S_SYNC:
        if (baud_tick) w_state_nxt = S_START;
      S_START:
        if (baud_tick) w_state_nxt = S_DATA;
      S_DATA:
        if (baud_tick && w_last_bit)
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY:
        if (baud_tick) w_state_nxt = S_STOP;
      S_STOP:
        if (baud_tick && w_last_stop)
          w_state_nxt = S_IDLE;
`ifdef UART_TX_BREAK_EN
      S_BREAK:
        if (baud_tick && !tx_break)
          w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  function automatic state_t S_IDLE_BRK();
`ifdef UART_TX_BREAK_EN
    return S_BREAK;
`else
    return S_IDLE;
`endif
  endfunction

  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_accept)
      w_shreg_nxt = tx_data;
    else if (baud_tick && r_state == S_DATA)
      w_shreg_nxt = r_shreg >> 1;
  end

  // tx is registered, so it is derived from the state being entered.
  always_comb begin
    w_tx_nxt = 1'b1;
    tx_ready = (r_state == S_IDLE);
    tx_done  = (r_state == S_STOP) & baud_tick & w_last_stop;
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
      S_PARITY: w_tx_nxt = r_par_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  w_tx_nxt = 1'b0;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      if (w_accept) begin
        r_par_en  <= parity_en;
        r_par_bit <= parity_odd ? ~^tx_data : ^tx_data;
      end
      if (baud_tick) begin
        r_bit_cnt  <= (r_state == S_DATA)
                    ? r_bit_cnt + CW'(1) : '0;
        r_stop_cnt <= (r_state == S_STOP)
                    ? ~r_stop_cnt : 1'b0;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule
